key_search_ctrl: RTL and testbench

//   Consumes the 64-bit ciphertext block and level done flag produced by the file reader.

---
 rtl/key_search_pkg.sv | 29 ++
 rtl/key_counter.sv | 31 +++
 rtl/key_search_ctrl.sv | 158 +++++++++++++++
 tb/tb_key_search_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_search_pkg.sv
// Shared types and constants for the key search controller: FSM state encoding,
// the default known plaintext and the watchdog width helper.
package key_search_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_CHECK   = 3'd4,
        ST_FOUND   = 3'd5,
        ST_EXHAUST = 3'd6,
        ST_ERROR   = 3'd7
    } state_e;

    localparam logic [63:0] KNOWN_PT_DEFAULT = 64'h2550_4446_2550_4446;

    // Watchdog only ever holds TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
    function automatic int timeout_width(input int timeout);
        int w;
        if (timeout <= 2) begin
            w = 1;
        end else begin
            w = $clog2(timeout);
        end
        return w;
    endfunction

endpackage

// File: rtl/key_counter.sv
// Candidate key register: loads KEY_FIRST, steps by one, flags the last key of the range.
module key_counter #(
    parameter int               KEY_W     = 56,
    parameter logic [KEY_W-1:0] KEY_FIRST = {KEY_W{1'b0}},
    parameter logic [KEY_W-1:0] KEY_LAST  = {KEY_W{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_inc,
    output logic [KEY_W-1:0] o_key,
    output logic             o_at_last
);

    logic [KEY_W-1:0] r_key;

    // Key register; load wins over increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_key <= {KEY_W{1'b0}};
        end else if (i_load) begin
            r_key <= KEY_FIRST;
        end else if (i_inc) begin
            r_key <= r_key + {{(KEY_W-1){1'b0}}, 1'b1};
        end
    end

    assign o_key     = r_key;
    assign o_at_last = (r_key == KEY_LAST);

endmodule

// File: rtl/key_search_ctrl.sv
// Sweeps candidate keys through an external decrypt core until the decrypted block
// equals the known plaintext, the range runs out, or the core stops answering.
module key_search_ctrl
    import key_search_pkg::*;
#(
    parameter int               KEY_W     = 56,
    parameter logic [KEY_W-1:0] KEY_FIRST = {KEY_W{1'b0}},
    parameter logic [KEY_W-1:0] KEY_LAST  = {KEY_W{1'b1}},
    parameter logic [63:0]      KNOWN_PT  = KNOWN_PT_DEFAULT,
    parameter int               TIMEOUT   = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [63:0]      cipher_in,
    input  logic             cipher_done,
    input  logic             clear,
    output logic             core_start,
    output logic [KEY_W-1:0] core_key,
    output logic [63:0]      core_block,
    input  logic             core_valid,
    input  logic [63:0]      core_result,
    output logic             busy,
    output logic             found,
    output logic [KEY_W-1:0] key_found,
    output logic             exhausted,
    output logic             error
);

    localparam int              WD_W    = timeout_width(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

    state_e           r_state;
    state_e           w_next;
    logic             r_done_d;
    logic [63:0]      r_block;
    logic [63:0]      r_result;
    logic [WD_W-1:0]  r_wd;
    logic             r_busy;
    logic             r_found;
    logic             r_exh;
    logic             r_err;
    logic [KEY_W-1:0] r_key_found;
    logic             w_done_rise;
    logic             w_load;
    logic             w_inc;
    logic             w_at_last;
    logic [KEY_W-1:0] w_key;

    assign w_done_rise = cipher_done & ~r_done_d;

    key_counter #(
        .KEY_W     (KEY_W),
        .KEY_FIRST (KEY_FIRST),
        .KEY_LAST  (KEY_LAST)
    ) u_key_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_load),
        .i_inc     (w_inc),
        .o_key     (w_key),
        .o_at_last (w_at_last)
    );

    // Next-state and counter control; clear overrides every other event.
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_inc  = 1'b0;
        if (clear) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_done_rise) w_next = ST_LOAD;
                    else             w_next = ST_IDLE;
                end
                ST_LOAD: begin
                    w_next = ST_ISSUE;
                    w_load = 1'b1;
                end
                ST_ISSUE: begin
                    w_next = ST_WAIT;
                end
                ST_WAIT: begin
                    // Timeout fires as the watchdog would step down to zero.
                    if (core_valid)          w_next = ST_CHECK;
                    else if (r_wd <= WD_ONE) w_next = ST_ERROR;
                    else                     w_next = ST_WAIT;
                end
                ST_CHECK: begin
                    if (r_result == KNOWN_PT) begin
                        w_next = ST_FOUND;
                    end else if (w_at_last) begin
                        w_next = ST_EXHAUST;
                    end else begin
                        w_next = ST_ISSUE;
                        w_inc  = 1'b1;
                    end
                end
                ST_FOUND, ST_EXHAUST, ST_ERROR: begin
                    w_next = r_state;
                end
                default: begin
                    w_next = ST_IDLE;
                end
            endcase
        end
    end

    // State, datapath captures, watchdog and registered status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_done_d    <= 1'b0;
            r_block     <= 64'h0;
            r_result    <= 64'h0;
            r_wd        <= {WD_W{1'b0}};
            r_busy      <= 1'b0;
            r_found     <= 1'b0;
            r_exh       <= 1'b0;
            r_err       <= 1'b0;
            r_key_found <= {KEY_W{1'b0}};
        end else begin
            r_state  <= w_next;
            r_done_d <= cipher_done;
            r_busy   <= (w_next == ST_LOAD) || (w_next == ST_ISSUE) ||
                        (w_next == ST_WAIT) || (w_next == ST_CHECK);
            r_found  <= (w_next == ST_FOUND);
            r_exh    <= (w_next == ST_EXHAUST);
            r_err    <= (w_next == ST_ERROR);
            if (w_load) begin
                r_block <= cipher_in;
            end
            if (r_state == ST_ISSUE) begin
                r_wd <= WD_LOAD;
            end else if (r_state == ST_WAIT) begin
                r_wd <= r_wd - WD_ONE;
            end
            if ((r_state == ST_WAIT) && core_valid) begin
                r_result <= core_result;
            end
            if ((r_state == ST_CHECK) && (w_next == ST_FOUND)) begin
                r_key_found <= w_key;
            end
        end
    end

    assign core_start = (r_state == ST_ISSUE) & ~clear;
    assign core_key   = w_key;
    assign core_block = r_block;
    assign busy       = r_busy;
    assign found      = r_found;
    assign key_found  = r_key_found;
    assign exhausted  = r_exh;
    assign error      = r_err;

endmodule

// File: tb/tb_key_search_ctrl.sv
// Bench for key_search_ctrl with 8-bit keys and a 3-cycle mock core (cipher ^ {8{key}}).
module tb_key_search_ctrl;

    localparam logic [63:0] KPT = 64'h2550_4446_2550_4446;

    localparam int K_TERM_A = 1;
    localparam int K_IDLE_A = 2;
    localparam int K_TERM_B = 3;
    localparam int K_LAT    = 4;
    localparam int K_PIN    = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [63:0] a_cipher, b_cipher;
    logic        a_done, b_done, a_clear, b_clear;
    logic        a_start, b_start, a_valid, b_valid;
    logic [7:0]  a_key, b_key, a_kf, b_kf;
    logic [63:0] a_block, b_block, a_result, b_result;
    logic        a_busy, b_busy, a_found, b_found, a_exh, b_exh, a_err, b_err;
    logic        a_mute = 1'b0;
    logic        a_inject = 1'b0;

    key_search_ctrl #(.KEY_W(8), .KEY_FIRST(8'h00), .KEY_LAST(8'hFF), .KNOWN_PT(KPT), .TIMEOUT(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .cipher_in(a_cipher), .cipher_done(a_done), .clear(a_clear),
        .core_start(a_start), .core_key(a_key), .core_block(a_block), .core_valid(a_valid),
        .core_result(a_result), .busy(a_busy), .found(a_found), .key_found(a_kf),
        .exhausted(a_exh), .error(a_err));

    key_search_ctrl #(.KEY_W(8), .KEY_FIRST(8'h5A), .KEY_LAST(8'h5A), .KNOWN_PT(KPT), .TIMEOUT(1024)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .cipher_in(b_cipher), .cipher_done(b_done), .clear(b_clear),
        .core_start(b_start), .core_key(b_key), .core_block(b_block), .core_valid(b_valid),
        .core_result(b_result), .busy(b_busy), .found(b_found), .key_found(b_kf),
        .exhausted(b_exh), .error(b_err));

    // Mock decrypt cores: fixed 3-cycle latency.
    logic [2:0]  a_vp = 3'b000, b_vp = 3'b000;
    logic [63:0] a_rp [3];
    logic [63:0] b_rp [3];
    always @(posedge clk) begin
        a_vp    <= {a_vp[1:0], a_start & ~a_mute};
        a_rp[0] <= a_block ^ {8{a_key}};
        a_rp[1] <= a_rp[0];
        a_rp[2] <= a_rp[1];
        b_vp    <= {b_vp[1:0], b_start};
        b_rp[0] <= b_block ^ {8{b_key}};
        b_rp[1] <= b_rp[0];
        b_rp[2] <= b_rp[1];
    end
    assign a_valid  = a_vp[2] | a_inject;
    assign a_result = a_rp[2];
    assign b_valid  = b_vp[2];
    assign b_result = b_rp[2];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: try keys in order, stop at the first whose decryption is the plaintext.
    function automatic void predict(input logic [63:0] c, input int first, input int last,
                                    output bit f, output int k, output int n);
        logic [7:0] kb;
        f = 1'b0; k = 0; n = 0;
        for (int i = first; i <= last; i++) begin
            kb = i[7:0];
            n++;
            if ((c ^ {8{kb}}) == KPT) begin
                f = 1'b1;
                k = i;
                break;
            end
        end
    endfunction

    int n_cmp = 0, n_bad = 0;
    int a_tot = 0, b_tot = 0, sweep_base = 0, b_base = 0, key_first = 0;
    int last_start = 0, start_cyc = 0, err_cyc = 0;
    logic [63:0] exp_block = 64'h0;
    logic a_chk = 1'b0;
    int req_seq = 0, done_seq = 0, req_kind = 0, req_n = 0, req_k = 0;
    bit req_f, req_x, req_e;
    logic [63:0] req_act, req_exp;
    string req_name = "";

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endfunction

    // Compare process: per-start key/block/spacing checks and requested end-of-scenario checks.
    initial begin : compare
        logic prev_err;
        prev_err = 1'b0;
        forever begin
            @(negedge clk);
            if (a_start) begin
                if (a_chk) begin
                    chk("core_key", {56'd0, a_key}, 64'(key_first + a_tot - sweep_base));
                    chk("core_block", a_block, exp_block);
                    if (a_tot != sweep_base) chk("start_gap", 64'(cyc - last_start), 64'd5);
                end
                if (a_tot == sweep_base) start_cyc = cyc;
                last_start = cyc;
                a_tot++;
            end
            if (b_start) b_tot++;
            if (a_err && !prev_err) err_cyc = cyc;
            prev_err = a_err;
            if (a_chk && (a_found || a_exh || a_err)) begin
                chk("busy_terminal", {63'd0, a_busy}, 64'd0);
                chk("start_terminal", {63'd0, a_start}, 64'd0);
            end
            if (req_seq != done_seq) begin
                case (req_kind)
                    K_TERM_A: begin
                        chk({req_name, ".found"}, {63'd0, a_found}, {63'd0, req_f});
                        chk({req_name, ".exhausted"}, {63'd0, a_exh}, {63'd0, req_x});
                        chk({req_name, ".error"}, {63'd0, a_err}, {63'd0, req_e});
                        chk({req_name, ".busy"}, {63'd0, a_busy}, 64'd0);
                        chk({req_name, ".starts"}, 64'(a_tot - sweep_base), 64'(req_n));
                        if (req_f) chk({req_name, ".key_found"}, {56'd0, a_kf}, 64'(req_k));
                    end
                    K_IDLE_A: begin
                        chk({req_name, ".flags"}, {59'd0, a_start, a_busy, a_found, a_exh, a_err}, 64'd0);
                        chk({req_name, ".core_key"}, {56'd0, a_key}, 64'd0);
                        chk({req_name, ".key_found"}, {56'd0, a_kf}, 64'd0);
                        chk({req_name, ".core_block"}, a_block, 64'd0);
                    end
                    K_TERM_B: begin
                        chk({req_name, ".found"}, {63'd0, b_found}, {63'd0, req_f});
                        chk({req_name, ".exhausted"}, {63'd0, b_exh}, {63'd0, req_x});
                        chk({req_name, ".error"}, {63'd0, b_err}, 64'd0);
                        chk({req_name, ".busy"}, {63'd0, b_busy}, 64'd0);
                        chk({req_name, ".starts"}, 64'(b_tot - b_base), 64'(req_n));
                        if (req_f) chk({req_name, ".key_found"}, {56'd0, b_kf}, 64'(req_k));
                    end
                    K_LAT:   chk(req_name, 64'(err_cyc - start_cyc), 64'(req_n));
                    K_PIN:   chk(req_name, req_act, req_exp);
                    default: chk("bad_request", 64'(req_kind), 64'd0);
                endcase
                done_seq = req_seq;
            end
        end
    end

    task automatic req(input int kind, input string nm);
        req_name = nm;
        req_kind = kind;
        req_seq++;
        for (int i = 0; i < 10 && done_seq != req_seq; i++) @(posedge clk);
        #1;
    endtask

    task automatic pin(input string nm, input logic [63:0] act, input logic [63:0] exp);
        req_act = act;
        req_exp = exp;
        req(K_PIN, nm);
    endtask

    task automatic term_a(input string nm, input bit f, input int k, input bit x, input bit e, input int n);
        req_f = f; req_k = k; req_x = x; req_e = e; req_n = n;
        req(K_TERM_A, nm);
    endtask

    task automatic pulse_clear_a();
        @(posedge clk); #1 a_clear = 1'b1;
        @(posedge clk); #1 a_clear = 1'b0;
    endtask

    // Start a sweep on DUT A with a fresh done edge and wait (bounded) for a terminal flag.
    task automatic sweep_a(input string nm, input logic [63:0] c,
                           input bit f, input int k, input bit x, input bit e, input int n);
        bit ok;
        ok = 1'b0;
        a_done = 1'b0;
        @(posedge clk); #1;
        a_cipher   = c;
        exp_block  = c;
        sweep_base = a_tot;
        key_first  = 0;
        a_chk      = 1'b1;
        a_done     = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (a_found || a_exh || a_err) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        pin({nm, ".terminated"}, {63'd0, ok}, 64'd1);
        term_a(nm, f, k, x, e, n);
    endtask

    task automatic sweep_b(input string nm, input logic [63:0] c);
        bit ok, f;
        int k, n;
        ok = 1'b0;
        predict(c, 8'h5A, 8'h5A, f, k, n);
        pin({nm, ".model_starts"}, 64'(n), 64'd1);
        b_clear = 1'b1;
        b_done  = 1'b0;
        @(posedge clk); #1;
        b_clear  = 1'b0;
        b_cipher = c;
        b_base   = b_tot;
        b_done   = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (b_found || b_exh || b_err) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        pin({nm, ".terminated"}, {63'd0, ok}, 64'd1);
        req_f = f; req_k = k; req_x = ~f; req_n = n;
        req(K_TERM_B, nm);
    endtask

    initial begin : stim
        logic [63:0] c1, c2, c;
        logic [7:0]  t;
        bit f;
        int k, n;
        bit ok;

        rst_n = 1'b0;
        a_cipher = 64'h0; b_cipher = 64'h0;
        a_done = 1'b0; b_done = 1'b0; a_clear = 1'b0; b_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        req(K_IDLE_A, "reset_state");
        rst_n = 1'b1;

        // Matching key 0x5A; hand-computed pins on the model.
        t  = 8'h5A;
        c1 = KPT ^ {8{t}};
        predict(c1, 0, 255, f, k, n);
        pin("model.t1_starts", 64'(n), 64'h5B);
        pin("model.t1_key", 64'(k), 64'h5A);
        sweep_a("t1_found", c1, f, k, 1'b0, 1'b0, n);

        // done still high: clear must not restart; then a fresh edge restarts from key 0.
        pulse_clear_a();
        sweep_base = a_tot;
        repeat (20) @(posedge clk);
        #1;
        term_a("t4_clear_no_restart", 1'b0, 0, 1'b0, 1'b0, 0);
        sweep_a("t4_restart", c1, f, k, 1'b0, 1'b0, n);

        // No key matches: full range, no wrap.
        pulse_clear_a();
        c2 = 64'h0123_4567_89AB_CDEF;
        predict(c2, 0, 255, f, k, n);
        pin("model.t2_starts", 64'(n), 64'd256);
        pin("model.t2_found", {63'd0, f}, 64'd0);
        sweep_a("t2_exhaust", c2, f, k, 1'b1, 1'b0, n);
        repeat (20) @(posedge clk);
        #1;
        term_a("t2_no_wrap", f, k, 1'b1, 1'b0, n);

        // Randomized sweeps, mostly matching, occasionally a random block.
        for (int it = 0; it < 5; it++) begin
            pulse_clear_a();
            t = 8'($urandom_range(0, 255));
            c = KPT ^ {8{t}};
            if (it == 4) c = {$urandom, $urandom};
            predict(c, 0, 255, f, k, n);
            sweep_a("rand_sweep", c, f, k, ~f, 1'b0, n);
        end

        // Silent core: error 16 cycles after the single start.
        pulse_clear_a();
        a_mute = 1'b1;
        sweep_a("t3_timeout", c1, 1'b0, 0, 1'b0, 1'b1, 1);
        req_n = 16;
        req(K_LAT, "t3_latency");
        repeat (20) @(posedge clk);
        #1;
        term_a("t3_single_start", 1'b0, 0, 1'b0, 1'b1, 1);
        a_mute = 1'b0;

        // Reset during WAIT with a stray core_valid in the same cycle.
        pulse_clear_a();
        a_done = 1'b0;
        a_chk  = 1'b0;
        @(posedge clk); #1;
        a_cipher = c1;
        a_done   = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (a_start) begin
                ok = 1'b1;
                break;
            end
        end
        pin("t5_saw_start", {63'd0, ok}, 64'd1);
        @(posedge clk); #1;
        rst_n    = 1'b0;
        a_inject = 1'b1;
        a_done   = 1'b0;
        @(posedge clk); #1;
        a_inject = 1'b0;
        req(K_IDLE_A, "t5_reset_in_wait");
        rst_n = 1'b1;
        sweep_base = a_tot;
        repeat (10) @(posedge clk);
        #1;
        term_a("t5_stray_ignored", 1'b0, 0, 1'b0, 1'b0, 0);

        // Single-key range on DUT B.
        sweep_b("t6_match", c1);
        sweep_b("t6_nomatch", KPT);

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
